// File: rtl/md_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int CNT_W = 4;

  // Multi-cycle ops (mult/div) occupy codes 0-3.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational multiply/divide datapath producing {hi,lo} from a, b and md_op.
// valid drops for division by zero and for non-arithmetic codes.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        valid
);

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);

  // Low 64 bits of the extended product are exact for both signednesses.
  assign a_ext = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  // Sign-magnitude division: magnitude of 0x80000000 is still representable
  // unsigned, so the -2^31 / -1 case yields 0x80000000 with no special path.
  assign a_neg = signed_op & a[31];
  assign b_neg = signed_op & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = (b == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b) : b);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    result = 64'd0;
    valid  = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU: begin
        result = prod;
        valid  = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result = {rem, quot};
        valid  = (b != 32'd0);
      end
      default: begin
        result = 64'd0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit: computes the result up front, then
// holds busy for a fixed latency before committing it to HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      calc_result;
  logic             calc_valid;

  md_calc u_calc (
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .result (calc_result),
    .valid  (calc_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(md_op)) begin
            pend_d    = calc_result;
            pend_wr_d = calc_valid;
            cnt_d     = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = ST_BUSY;
          end else if (md_op == MD_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_BUSY: begin
        // start is deliberately ignored here; only the countdown advances.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = md_in_d & (busy | (start & is_long_op(md_op)));

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, giving the busy cycles for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, giving the busy cycles for DIV/DIVU.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO; valid for one cycle.
REQ-006 md_op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-007 a  input  32  operand rs, the forwarded ID/EX first read data.
REQ-008 b  input  32  operand rt, the forwarded ID/EX second read data.
REQ-009 md_in_d  input  1  ID-stage instruction uses the unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 busy  output  1  a multi-cycle operation is in progress.
REQ-011 hi  output  32  architectural HI register.
REQ-012 lo  output  32  architectural LO register.
REQ-013 stall_req  output  1  hold IF/ID and flush ID/EX this cycle.

Function
REQ-014 Two states SHALL be used: IDLE and BUSY, plus a 4-bit down-counter and a 64-bit pending-result register.
REQ-015 In IDLE with start=1 and md_op 0-3, the result SHALL be computed into pending at that edge, the counter loaded with MULT_CYCLES or DIV_CYCLES, and the unit SHALL go to BUSY.
REQ-016 In BUSY the counter SHALL decrement each edge; on the edge where it equals 1, {hi,lo} SHALL take pending and the unit SHALL return to IDLE.
REQ-017 Latency: start sampled at edge N -> busy=1 from N to N+k, hi/lo visible and busy=0 after edge N+k (k = 5 mult, 10 div).
REQ-018 MULT SHALL produce the signed 64-bit product, and MULTU the unsigned one, with hi = [63:32] and lo = [31:0].
REQ-019 DIV/DIVU SHALL set lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Division by zero SHALL still occupy DIV_CYCLES but SHALL leave hi/lo unchanged.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write a to hi/lo at that edge with no busy cycle.
REQ-023 start while BUSY SHALL be ignored, with no state or result change.
REQ-024 Reserved md_op values with start=1 SHALL have no effect.
REQ-025 stall_req SHALL equal md_in_d & (busy | (start & md_op<=3)), combinationally.
REQ-026 hi and lo SHALL change only per REQ-016, REQ-022 or reset.

Reset
REQ-027 reset=0 SHALL immediately force the state to IDLE and clear counter, pending, hi and lo to 0; busy SHALL read 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; hi/lo SHALL remain 0 after release.
REQ-029 The first start SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-030 The md_op codes and the state encoding SHALL live in the shared CPU definitions package.
REQ-031 A single sub-module, md_calc, SHALL hold the combinational multiply/divide producing 64-bit {hi,lo} from a, b and md_op.
REQ-032 The pipeline register feeding EX SHALL receive flush = stall_req; the IF/ID register and PC SHALL receive enable = ~stall_req.

Verification
REQ-033 MULT a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-034 DIV a=-7, b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-035 DIV with b=0 after MTHI a=0x11 -> busy for 10 cycles, hi stays 0x11.
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF with md_in_d=1 throughout -> stall_req=1 for the start cycle plus 5 busy cycles; hi=0xFFFFFFFE, lo=1.
REQ-037 Reset pulsed at cycle 3 of a DIV -> busy=0 at once, hi=lo=0, and a following MTLO a=5 gives lo=5.
REQ-038 start with MULT at busy cycle 2 of a prior MULTU -> ignored; only the MULTU result is written.
